// File: rtl/instruction_fetch_stage.sv
// Fetch stage with IF/ID pipeline register: PC, ready-handshake fetch, one-entry
// skid buffer for fetches that land during a stall, and decode-side redirect/flush.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallInput,
  input  logic        branchControlInput,
  input  logic [31:0] pcBranchInput,
  input  logic        jumpInput,
  input  logic [31:0] pcJumpInput,
  input  logic        ifFlushInput,
  output logic        imemReqOutput,
  output logic [31:0] imemAddrOutput,
  input  logic        imemReadyInput,
  input  logic [31:0] imemDataInput,
  output logic [31:0] instructionOutput,
  output logic [31:0] pc4Output,
  output logic        validOutput,
  output logic [31:0] pcOutput
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] skid_q, skid_d, skid_pc4_q, skid_pc4_d;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        active_q;

  logic        redirect, req, fire;
  logic [31:0] target, pc_inc;

  assign redirect = jumpInput | branchControlInput;
  assign target   = (jumpInput ? pcJumpInput : pcBranchInput) & 32'hFFFF_FFFC;
  assign pc_inc   = pc_q + 32'd4;
  // active_q keeps the request low for the first cycle out of reset
  assign req      = active_q && (state_q != HOLD);
  assign fire     = req && imemReadyInput;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    skid_d      = skid_q;
    skid_pc4_d  = skid_pc4_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d       = target;
          skid_d     = '0;
          skid_pc4_d = '0;
          if (req && !imemReadyInput) begin
            state_d     = DROP;
            drop_addr_d = pc_q;
          end
        end else if (fire && !stallInput) begin
          instr_d = imemDataInput;
          pc4_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end else if (fire) begin
          skid_d     = imemDataInput;
          skid_pc4_d = pc_inc;
          pc_d       = pc_inc;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d       = target;
          skid_d     = '0;
          skid_pc4_d = '0;
          state_d    = FETCH;
        end else if (!stallInput) begin
          instr_d = skid_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end
      DROP: begin
        // the in-flight return belongs to the squashed path; swallow it
        if (redirect) pc_d = target;
        if (fire) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (ifFlushInput) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      skid_q      <= '0;
      skid_pc4_q  <= '0;
      instr_q     <= NOP_INSTR;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      skid_q      <= skid_d;
      skid_pc4_q  <= skid_pc4_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      active_q    <= 1'b1;
    end
  end

  assign imemReqOutput     = req;
  assign imemAddrOutput    = (state_q == DROP) ? drop_addr_q : pc_q;
  assign instructionOutput = instr_q;
  assign pc4Output         = pc4_q;
  assign validOutput       = valid_q;
  assign pcOutput          = pc_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: a flag/queue reference model checked
// every negedge, plus literal expectations at the interesting points.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stallInput = 1'b0, branchControlInput = 1'b0, jumpInput = 1'b0;
  logic        ifFlushInput = 1'b0, imemReadyInput = 1'b0;
  logic [31:0] pcBranchInput = '0, pcJumpInput = '0;
  logic        imemReqOutput, validOutput;
  logic [31:0] imemAddrOutput, imemDataInput, instructionOutput, pc4Output, pcOutput;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  instruction_fetch_stage dut (
    .clk(clk), .reset(reset), .stallInput(stallInput),
    .branchControlInput(branchControlInput), .pcBranchInput(pcBranchInput),
    .jumpInput(jumpInput), .pcJumpInput(pcJumpInput), .ifFlushInput(ifFlushInput),
    .imemReqOutput(imemReqOutput), .imemAddrOutput(imemAddrOutput),
    .imemReadyInput(imemReadyInput), .imemDataInput(imemDataInput),
    .instructionOutput(instructionOutput), .pc4Output(pc4Output),
    .validOutput(validOutput), .pcOutput(pcOutput)
  );

  always #5 clk = ~clk;

  // memory image: mem[a] = a + 0x100
  assign imemDataInput = imemAddrOutput + 32'h100;

  // reference model: pending junk fetch flag, queue of one held fetch
  logic        m_active, m_discard, m_valid;
  logic [31:0] m_pc, m_iaddr, m_instr, m_pc4;
  logic [63:0] m_held[$];

  task automatic model_reset();
    m_active = 0; m_discard = 0; m_valid = 0;
    m_pc = 0; m_iaddr = 0; m_instr = 0; m_pc4 = 0;
    m_held.delete();
  endtask

  task automatic model_update();
    logic        redir, rq;
    logic [31:0] tgt, a;
    logic [63:0] h;
    redir = jumpInput | branchControlInput;
    tgt   = jumpInput ? pcJumpInput : pcBranchInput;
    tgt[1:0] = 2'b00;
    rq = m_active && (m_held.size() == 0);
    a  = m_discard ? m_iaddr : m_pc;
    if (m_discard) begin
      if (redir) m_pc = tgt;
      if (imemReadyInput) m_discard = 0;
    end else if (m_held.size() != 0) begin
      if (redir) begin
        m_held.delete();
        m_pc = tgt;
      end else if (!stallInput) begin
        h = m_held.pop_front();
        m_instr = h[63:32]; m_pc4 = h[31:0]; m_valid = 1;
      end
    end else if (redir) begin
      if (rq && !imemReadyInput) begin
        m_discard = 1;
        m_iaddr = m_pc;
      end
      m_pc = tgt;
    end else if (rq && imemReadyInput) begin
      if (stallInput) m_held.push_back({a + 32'h100, m_pc + 32'd4});
      else begin
        m_instr = a + 32'h100; m_pc4 = m_pc + 32'd4; m_valid = 1;
      end
      m_pc = m_pc + 32'd4;
    end
    if (ifFlushInput) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end
    m_active = 1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("m_req",   {31'b0, imemReqOutput}, {31'b0, m_active && (m_held.size() == 0)});
      chk("m_addr",  imemAddrOutput, m_discard ? m_iaddr : m_pc);
      chk("m_instr", instructionOutput, m_instr);
      chk("m_pc4",   pc4Output, m_pc4);
      chk("m_valid", {31'b0, validOutput}, {31'b0, m_valid});
      chk("m_pc",    pcOutput, m_pc);
    end
  end

  task automatic step(input logic r, input logic s, input logic f,
                      input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    imemReadyInput = r; stallInput = s; ifFlushInput = f;
    branchControlInput = b; pcBranchInput = bt;
    jumpInput = j; pcJumpInput = jt;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'b0, imemReqOutput}, 32'h0);
    chk({tag, "_addr"},  imemAddrOutput, 32'h0);
    chk({tag, "_instr"}, instructionOutput, 32'h0);
    chk({tag, "_pc4"},   pc4Output, 32'h0);
    chk({tag, "_valid"}, {31'b0, validOutput}, 32'h0);
    chk({tag, "_pc"},    pcOutput, 32'h0);
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("rst");
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    chk("first_req", {31'b0, imemReqOutput}, 32'h1);
    chk("first_addr", imemAddrOutput, 32'h0);

    // zero-wait fetches
    step(1, 0, 0, 0, 0, 0, 0);
    chk("f0_instr", instructionOutput, 32'h100);
    chk("f0_pc4", pc4Output, 32'h4);
    chk("f0_valid", {31'b0, validOutput}, 32'h1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("f1_instr", instructionOutput, 32'h104);
    chk("f1_pc4", pc4Output, 32'h8);

    // ready delayed 3 cycles at pc 0x8
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk("wait_req", {31'b0, imemReqOutput}, 32'h1);
      chk("wait_addr", imemAddrOutput, 32'h8);
      chk("wait_instr", instructionOutput, 32'h104);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    chk("late_instr", instructionOutput, 32'h108);
    chk("late_pc", pcOutput, 32'hC);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("f3_instr", instructionOutput, 32'h10C);

    // fetch of 0x10 lands during a 2-cycle stall
    step(1, 1, 0, 0, 0, 0, 0);
    chk("stall_instr", instructionOutput, 32'h10C);
    chk("stall_req", {31'b0, imemReqOutput}, 32'h0);
    chk("stall_pc", pcOutput, 32'h14);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("stall2_instr", instructionOutput, 32'h10C);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("skid_instr", instructionOutput, 32'h110);
    chk("skid_pc4", pc4Output, 32'h14);
    chk("skid_addr", imemAddrOutput, 32'h14);

    // branch + flush while the fetch of 0x14 is pending
    step(0, 0, 1, 1, 32'h40, 0, 0);
    chk("br_valid", {31'b0, validOutput}, 32'h0);
    chk("br_addr_held", imemAddrOutput, 32'h14);
    chk("br_pc", pcOutput, 32'h40);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("drop_valid", {31'b0, validOutput}, 32'h0);
    chk("drop_instr", instructionOutput, 32'h0);
    chk("drop_addr", imemAddrOutput, 32'h40);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("tgt_instr", instructionOutput, 32'h140);
    chk("tgt_pc4", pc4Output, 32'h44);

    // jump beats branch; misaligned target is truncated
    step(0, 0, 0, 1, 32'h40, 1, 32'h80);
    chk("jb_pc", pcOutput, 32'h80);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("jb_addr", imemAddrOutput, 32'h80);
    step(1, 0, 0, 0, 0, 1, 32'h83);
    chk("mis_addr", imemAddrOutput, 32'h80);
    chk("mis_instr", instructionOutput, 32'h140);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("mis_fetch", instructionOutput, 32'h180);
    chk("mis_pc4", pc4Output, 32'h84);

    // PC wrap at the top of the address space
    step(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("wrap_instr", instructionOutput, 32'h0000_00FC);
    chk("wrap_pc4", pc4Output, 32'h0);
    chk("wrap_pc", pcOutput, 32'h0);

    // async reset while a skid entry is held
    step(1, 1, 0, 0, 0, 0, 0);
    chk("hold_req", {31'b0, imemReqOutput}, 32'h0);
    #2 reset = 1'b0;
    model_reset();
    #1 chk_reset_vals("midrst");
    @(posedge clk);
    #1 reset = 1'b1;
    stallInput = 1'b0; imemReadyInput = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    chk("restart_addr", imemAddrOutput, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("restart_instr", instructionOutput, 32'h100);
    chk("restart_pc4", pc4Output, 32'h4);

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
